irq_controller: RTL and testbench



---
 rtl/irq_controller_pkg.sv | 35 +++
 rtl/irq_source_latch.sv | 45 ++++
 rtl/irq_controller.sv | 166 ++++++++++++++++
 tb/tb_irq_controller.sv | 486 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_controller_pkg.sv
// Shared definitions for the interrupt controller: register offsets inside
// the 4-byte bus window, FSM state encoding, default address window base,
// and the fixed-priority pick used by the arbiter.
package irq_controller_pkg;

    // Default base of the register window (BASE_ADDR..BASE_ADDR+3)
    localparam logic [7:0] DEFAULT_BASE_ADDR = 8'hE0;

    // Register offsets relative to BASE_ADDR
    localparam logic [1:0] OFF_PENDING = 2'd0;
    localparam logic [1:0] OFF_MASK    = 2'd1;
    localparam logic [1:0] OFF_ACTIVE  = 2'd2;
    localparam logic [1:0] OFF_MODE    = 2'd3;

    // Handshake FSM with the processor
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAISE   = 2'd1,
        SERVICE = 2'd2
    } state_t;

    // Index of the lowest set bit; index 0 is the highest priority source.
    // Returns 0 for an all-zero vector, callers gate on |v.
    function automatic logic [2:0] lowest_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_source_latch.sv
// One interrupt channel: level/rising-edge detection, the pending flop,
// write-1-to-clear and post-acknowledge blanking for level sources.
module irq_source_latch (
    input  logic CLK,
    input  logic RESET,
    input  logic raise,
    input  logic edge_mode,
    input  logic w1c,
    input  logic accept,
    input  logic ack,
    output logic pending
);

    logic prev;
    logic ack_d;
    logic blank;
    logic set_req;

    // Blanking spans the SRC_ACK cycle and the one after it, so a device
    // that drops its level request one cycle after the ack does not re-pend.
    always_comb begin
        blank   = ack | ack_d;
        set_req = edge_mode ? (raise & ~prev) : (raise & ~blank);
    end

    // Pending flop: acceptance beats a new set, a new set beats W1C
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            prev    <= 1'b0;
            ack_d   <= 1'b0;
            pending <= 1'b0;
        end else begin
            prev  <= raise;
            ack_d <= ack;
            if (accept) begin
                pending <= 1'b0;
            end else if (set_req) begin
                pending <= 1'b1;
            end else if (w1c) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Bus-mapped interrupt controller: N_SOURCES maskable level/edge channels,
// fixed priority (index 0 highest), single raise/ack pair to the CPU.
// Bus handshake: a write takes effect at the edge where BUS_WE=1 and the
// address is in the window; a read sampled at edge k is driven onto
// BUS_DATA for exactly the cycle after edge k, otherwise BUS_DATA is Z.
module irq_controller
    import irq_controller_pkg::*;
#(
    parameter int         N_SOURCES = 8,
    parameter logic [7:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
    input  logic                 CLK,
    input  logic                 RESET,
    inout  wire  [7:0]           BUS_DATA,
    input  logic [7:0]           BUS_ADDR,
    input  logic                 BUS_WE,
    input  logic [N_SOURCES-1:0] SRC_RAISE,
    output logic [N_SOURCES-1:0] SRC_ACK,
    output logic                 CPU_IRQ_RAISE,
    input  logic                 CPU_IRQ_ACK,
    output state_t               dbg_state
);

    state_t state;
    state_t state_next;

    logic [7:0]           offset;
    logic                 in_win;
    logic [1:0]           reg_sel;
    logic                 bus_wr;
    logic                 bus_rd;

    logic [N_SOURCES-1:0] mask;
    logic [N_SOURCES-1:0] mode;
    logic [N_SOURCES-1:0] pending;
    logic [N_SOURCES-1:0] eligible;
    logic [N_SOURCES-1:0] w1c_vec;
    logic [N_SOURCES-1:0] ack_onehot;
    logic [2:0]           winner;
    logic [2:0]           active_id;
    logic                 active_valid;
    logic                 accept;
    logic                 eoi;
    logic                 latch_id;

    logic [7:0]           rd_mux;
    logic [7:0]           rd_data_q;
    logic                 rd_en_q;

    // Address decode; the subtraction wraps so only BASE..BASE+3 land below 4
    always_comb begin
        offset  = BUS_ADDR - BASE_ADDR;
        in_win  = (offset < 8'd4);
        reg_sel = offset[1:0];
        bus_wr  = in_win & BUS_WE;
        bus_rd  = in_win & ~BUS_WE;
        w1c_vec = (bus_wr && reg_sel == OFF_PENDING) ? BUS_DATA[N_SOURCES-1:0] : '0;
        eoi     = bus_wr && (reg_sel == OFF_ACTIVE) && (state == SERVICE);
    end

    // Arbitration and the one-hot acknowledge for the latched source
    always_comb begin
        eligible = pending & mask;
        winner   = lowest_index(8'(eligible));
        for (int i = 0; i < N_SOURCES; i++) begin
            ack_onehot[i] = accept && (active_id == 3'(i));
        end
    end

    genvar g;
    generate
        for (g = 0; g < N_SOURCES; g++) begin : gen_src
            irq_source_latch u_latch (
                .CLK       (CLK),
                .RESET     (RESET),
                .raise     (SRC_RAISE[g]),
                .edge_mode (mode[g]),
                .w1c       (w1c_vec[g]),
                .accept    (ack_onehot[g]),
                .ack       (SRC_ACK[g]),
                .pending   (pending[g])
            );
        end
    endgenerate

    // FSM state register
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|eligible) state_next = RAISE;
            RAISE:   if (CPU_IRQ_ACK) state_next = SERVICE;
            SERVICE: if (eoi) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs; the raise line comes straight from the state flop
    always_comb begin
        CPU_IRQ_RAISE = (state == RAISE);
        active_valid  = (state != IDLE);
        accept        = (state == RAISE) && CPU_IRQ_ACK;
        latch_id      = (state == IDLE) && (|eligible);
        dbg_state     = state;
    end

    // Latched winner and the one-cycle per-device acknowledge
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            active_id <= 3'd0;
            SRC_ACK   <= '0;
        end else begin
            if (latch_id) begin
                active_id <= winner;
            end
            SRC_ACK <= ack_onehot;
        end
    end

    // Writable configuration registers
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            mask <= '0;
            mode <= '0;
        end else if (bus_wr) begin
            if (reg_sel == OFF_MASK) mask <= BUS_DATA[N_SOURCES-1:0];
            if (reg_sel == OFF_MODE) mode <= BUS_DATA[N_SOURCES-1:0];
        end
    end

    // Read mux over pre-edge register values; unused upper bits read 0
    always_comb begin
        rd_mux = 8'h00;
        case (reg_sel)
            OFF_PENDING: rd_mux = 8'(pending);
            OFF_MASK:    rd_mux = 8'(mask);
            OFF_ACTIVE:  rd_mux = {active_valid, 4'b0000, active_id};
            OFF_MODE:    rd_mux = 8'(mode);
            default:     rd_mux = 8'h00;
        endcase
    end

    // Read data is captured at the request edge and driven for one cycle
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            rd_en_q   <= 1'b0;
            rd_data_q <= 8'h00;
        end else begin
            rd_en_q <= bus_rd;
            if (bus_rd) begin
                rd_data_q <= rd_mux;
            end
        end
    end

    assign BUS_DATA = rd_en_q ? rd_data_q : 8'bzzzz_zzzz;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios plus a random
// phase compared against a behavioural reference model.
module tb_irq_controller;
    import irq_controller_pkg::*;

    localparam logic [7:0] BASE = 8'hE0;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    wire  [7:0] BUS_DATA;
    logic [7:0] BUS_ADDR = 8'h00;
    logic       BUS_WE = 1'b0;
    logic [7:0] SRC_RAISE = 8'h00;
    logic [7:0] SRC_ACK;
    logic       CPU_IRQ_RAISE;
    logic       CPU_IRQ_ACK = 1'b0;
    state_t     dbg_state;

    logic [7:0] tb_drive = 8'h00;
    logic       tb_drive_en = 1'b0;
    assign BUS_DATA = tb_drive_en ? tb_drive : 8'bzzzz_zzzz;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    irq_controller #(.N_SOURCES(8), .BASE_ADDR(BASE)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .BUS_DATA      (BUS_DATA),
        .BUS_ADDR      (BUS_ADDR),
        .BUS_WE        (BUS_WE),
        .SRC_RAISE     (SRC_RAISE),
        .SRC_ACK       (SRC_ACK),
        .CPU_IRQ_RAISE (CPU_IRQ_RAISE),
        .CPU_IRQ_ACK   (CPU_IRQ_ACK),
        .dbg_state     (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    // phase: 0 = waiting, 1 = requesting the CPU, 2 = CPU servicing
    bit [7:0] m_pend, m_mask, m_mode, m_prev, m_ack;
    int       m_blank [8];
    int       m_phase;
    int       m_id;
    bit       m_raise;
    bit       m_rd_valid;
    bit [7:0] m_rd_data;

    task automatic model_step();
        int       off;
        bit       wr, rd, accept, blanked, set_i, clr_i;
        bit [7:0] elig, np;
        if (!RESET) begin
            m_pend = 0; m_mask = 0; m_mode = 0; m_prev = 0; m_ack = 0;
            for (int i = 0; i < 8; i++) m_blank[i] = 0;
            m_phase = 0; m_id = 0; m_raise = 0; m_rd_valid = 0; m_rd_data = 0;
        end else begin
            off = int'(BUS_ADDR) - int'(BASE);
            wr = (off >= 0) && (off <= 3) && BUS_WE;
            rd = (off >= 0) && (off <= 3) && !BUS_WE;
            m_rd_valid = rd;
            if (rd) begin
                case (off)
                    0: m_rd_data = m_pend;
                    1: m_rd_data = m_mask;
                    2: m_rd_data = {(m_phase != 0), 4'b0000, 3'(m_id)};
                    default: m_rd_data = m_mode;
                endcase
            end
            accept = (m_phase == 1) && CPU_IRQ_ACK;
            elig = m_pend & m_mask;
            for (int i = 0; i < 8; i++) begin
                blanked = m_blank[i] > 0;
                if (blanked) m_blank[i] = m_blank[i] - 1;
                set_i = m_mode[i] ? (SRC_RAISE[i] && !m_prev[i]) : (SRC_RAISE[i] && !blanked);
                clr_i = wr && (off == 0) && tb_drive[i];
                if (accept && m_id == i) np[i] = 1'b0;
                else if (set_i)          np[i] = 1'b1;
                else if (clr_i)          np[i] = 1'b0;
                else                     np[i] = m_pend[i];
            end
            m_ack = accept ? (8'd1 << m_id) : 8'd0;
            if (accept) m_blank[m_id] = 2;
            case (m_phase)
                0: if (elig != 0) begin
                       m_phase = 1;
                       for (int i = 7; i >= 0; i--) if (elig[i]) m_id = i;
                   end
                1: if (accept) m_phase = 2;
                default: if (wr && off == 2) m_phase = 0;
            endcase
            if (wr && off == 1) m_mask = tb_drive;
            if (wr && off == 3) m_mode = tb_drive;
            m_pend  = np;
            m_prev  = SRC_RAISE;
            m_raise = (m_phase == 1);
        end
    endtask

    always @(posedge CLK) model_step();

    // Scoreboard for the random phase, sampled mid-cycle
    always @(negedge CLK) begin
        if (chk_en && RESET) begin
            checks++;
            if (CPU_IRQ_RAISE !== m_raise) begin
                errors++;
                $display("FAIL rand_cpu_raise t=%0t got %b exp %b", $time, CPU_IRQ_RAISE, m_raise);
            end
            checks++;
            if (SRC_ACK !== m_ack) begin
                errors++;
                $display("FAIL rand_src_ack t=%0t got %h exp %h", $time, SRC_ACK, m_ack);
            end
            if (m_rd_valid) begin
                checks++;
                if (BUS_DATA !== m_rd_data) begin
                    errors++;
                    $display("FAIL rand_read t=%0t got %h exp %h", $time, BUS_DATA, m_rd_data);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        BUS_ADDR = a; BUS_WE = 1'b1; tb_drive = d; tb_drive_en = 1'b1;
        tick();
        BUS_WE = 1'b0; tb_drive_en = 1'b0; BUS_ADDR = 8'h00;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
        BUS_ADDR = a; BUS_WE = 1'b0;
        tick();
        BUS_ADDR = 8'h00;
        @(negedge CLK);
        d = BUS_DATA;
        tick();
    endtask

    task automatic pulse_ack();
        CPU_IRQ_ACK = 1'b1;
        tick();
        CPU_IRQ_ACK = 1'b0;
    endtask

    task automatic pulse_src(input logic [7:0] v);
        SRC_RAISE = v;
        tick();
        SRC_RAISE = 8'h00;
    endtask

    task automatic wait_raise(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (CPU_IRQ_RAISE === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [7:0] d;
        RESET = 1'b0;
        tick(); tick();
        RESET = 1'b1;
        @(negedge CLK);
        checks++;
        if (CPU_IRQ_RAISE !== 1'b0) begin
            errors++; $display("FAIL reset_cpu_raise got %b exp 0", CPU_IRQ_RAISE);
        end
        checks++;
        if (SRC_ACK !== 8'h00) begin
            errors++; $display("FAIL reset_src_ack got %h exp 00", SRC_ACK);
        end
        tick();
        for (int k = 0; k < 4; k++) begin
            bus_read(BASE + 8'(k), d);
            checks++;
            if (d !== 8'h00) begin
                errors++; $display("FAIL reset_reg%0d got %h exp 00", k, d);
            end
        end
    endtask

    task automatic test_level_handshake();
        logic [7:0] d;
        bit ok;
        bus_write(BASE + 8'd3, 8'h00);
        bus_write(BASE + 8'd1, 8'h03);
        SRC_RAISE = 8'h02;
        wait_raise(3, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL level_raise_timeout got 0 exp 1");
        end
        bus_read(BASE + 8'd2, d);
        checks++;
        if (d !== 8'h81) begin
            errors++; $display("FAIL level_active got %h exp 81", d);
        end
        pulse_ack();
        @(negedge CLK);
        checks++;
        if (SRC_ACK !== 8'h02) begin
            errors++; $display("FAIL level_src_ack got %h exp 02", SRC_ACK);
        end
        checks++;
        if (CPU_IRQ_RAISE !== 1'b0) begin
            errors++; $display("FAIL level_raise_drop got %b exp 0", CPU_IRQ_RAISE);
        end
        tick();
        SRC_RAISE = 8'h00;
        @(negedge CLK);
        checks++;
        if (SRC_ACK !== 8'h00) begin
            errors++; $display("FAIL level_ack_width got %h exp 00", SRC_ACK);
        end
        tick();
        bus_read(BASE, d);
        checks++;
        if (d !== 8'h00) begin
            errors++; $display("FAIL level_no_relatch got %h exp 00", d);
        end
        bus_write(BASE + 8'd2, 8'h00);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            checks++;
            if (CPU_IRQ_RAISE !== 1'b0) begin
                errors++; $display("FAIL level_idle_after_eoi got %b exp 0", CPU_IRQ_RAISE);
            end
            tick();
        end
        bus_read(BASE + 8'd2, d);
        checks++;
        if (d[7] !== 1'b0) begin
            errors++; $display("FAIL level_valid_cleared got %b exp 0", d[7]);
        end
    endtask

    task automatic test_priority();
        logic [7:0] d;
        bit ok;
        bus_write(BASE + 8'd1, 8'hFF);
        pulse_src(8'h24);
        wait_raise(3, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL prio_raise1_timeout got 0 exp 1");
        end
        bus_read(BASE + 8'd2, d);
        checks++;
        if (d !== 8'h82) begin
            errors++; $display("FAIL prio_active1 got %h exp 82", d);
        end
        pulse_ack();
        @(negedge CLK);
        checks++;
        if (SRC_ACK !== 8'h04) begin
            errors++; $display("FAIL prio_ack1 got %h exp 04", SRC_ACK);
        end
        tick();
        bus_write(BASE + 8'd2, 8'h00);
        wait_raise(3, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL prio_raise2_timeout got 0 exp 1");
        end
        bus_read(BASE + 8'd2, d);
        checks++;
        if (d !== 8'h85) begin
            errors++; $display("FAIL prio_active2 got %h exp 85", d);
        end
        pulse_ack();
        @(negedge CLK);
        checks++;
        if (SRC_ACK !== 8'h20) begin
            errors++; $display("FAIL prio_ack2 got %h exp 20", SRC_ACK);
        end
        tick();
        bus_write(BASE + 8'd2, 8'h00);
    endtask

    task automatic test_mask_w1c();
        logic [7:0] d;
        bus_write(BASE + 8'd1, 8'h00);
        bus_write(BASE + 8'd3, 8'h08);
        pulse_src(8'h08);
        tick();
        bus_read(BASE, d);
        checks++;
        if (d !== 8'h08) begin
            errors++; $display("FAIL w1c_edge_pend got %h exp 08", d);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            checks++;
            if (CPU_IRQ_RAISE !== 1'b0) begin
                errors++; $display("FAIL w1c_masked_raise got %b exp 0", CPU_IRQ_RAISE);
            end
            tick();
        end
        // W1C in the same cycle as a fresh rising edge: the set must win
        SRC_RAISE = 8'h08;
        BUS_ADDR = BASE; BUS_WE = 1'b1; tb_drive = 8'h08; tb_drive_en = 1'b1;
        tick();
        BUS_WE = 1'b0; tb_drive_en = 1'b0; BUS_ADDR = 8'h00; SRC_RAISE = 8'h00;
        bus_read(BASE, d);
        checks++;
        if (d !== 8'h08) begin
            errors++; $display("FAIL w1c_set_wins got %h exp 08", d);
        end
        bus_write(BASE, 8'h08);
        bus_read(BASE, d);
        checks++;
        if (d !== 8'h00) begin
            errors++; $display("FAIL w1c_clear got %h exp 00", d);
        end
        bus_read(BASE + 8'd3, d);
        checks++;
        if (d !== 8'h08) begin
            errors++; $display("FAIL w1c_mode_read got %h exp 08", d);
        end
        bus_write(BASE + 8'd3, 8'h00);
    endtask

    task automatic test_service_block();
        logic [7:0] d;
        bit ok;
        bus_write(BASE + 8'd1, 8'hFF);
        pulse_src(8'h02);
        wait_raise(3, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL svc_first_raise_timeout got 0 exp 1");
        end
        pulse_ack();
        tick();
        pulse_src(8'h01);
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            checks++;
            if (CPU_IRQ_RAISE !== 1'b0) begin
                errors++; $display("FAIL svc_blocked got %b exp 0", CPU_IRQ_RAISE);
            end
            tick();
        end
        bus_read(BASE, d);
        checks++;
        if (d !== 8'h01) begin
            errors++; $display("FAIL svc_accumulate got %h exp 01", d);
        end
        pulse_ack();
        @(negedge CLK);
        checks++;
        if (SRC_ACK !== 8'h00) begin
            errors++; $display("FAIL svc_ack_ignored got %h exp 00", SRC_ACK);
        end
        tick();
        bus_write(BASE + 8'd2, 8'h00);
        @(negedge CLK);
        checks++;
        if (CPU_IRQ_RAISE !== 1'b0) begin
            errors++; $display("FAIL svc_eoi_edge_raise got %b exp 0", CPU_IRQ_RAISE);
        end
        wait_raise(2, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL svc_raise_after_eoi got 0 exp 1");
        end
        bus_read(BASE + 8'd2, d);
        checks++;
        if (d !== 8'h80) begin
            errors++; $display("FAIL svc_active got %h exp 80", d);
        end
        pulse_ack();
        tick();
        bus_write(BASE + 8'd2, 8'h00);
        tick();
        pulse_ack();
        @(negedge CLK);
        checks++;
        if (SRC_ACK !== 8'h00) begin
            errors++; $display("FAIL idle_ack_ignored got %h exp 00", SRC_ACK);
        end
        tick();
    endtask

    task automatic test_reset_mid_raise();
        logic [7:0] d;
        bit ok;
        bus_write(BASE + 8'd1, 8'hFF);
        bus_write(BASE + 8'd3, 8'h0F);
        pulse_src(8'h08);
        wait_raise(3, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL rst_mid_raise_timeout got 0 exp 1");
        end
        RESET = 1'b0; CPU_IRQ_ACK = 1'b1;
        tick();
        CPU_IRQ_ACK = 1'b0;
        @(negedge CLK);
        checks++;
        if (CPU_IRQ_RAISE !== 1'b0) begin
            errors++; $display("FAIL rst_mid_cpu_raise got %b exp 0", CPU_IRQ_RAISE);
        end
        checks++;
        if (SRC_ACK !== 8'h00) begin
            errors++; $display("FAIL rst_mid_src_ack got %h exp 00", SRC_ACK);
        end
        tick();
        RESET = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus_read(BASE + 8'(k), d);
            checks++;
            if (d !== 8'h00) begin
                errors++; $display("FAIL rst_mid_reg%0d got %h exp 00", k, d);
            end
        end
    endtask

    task automatic test_random();
        bit last_rd;
        int r;
        last_rd = 1'b0;
        chk_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) SRC_RAISE = 8'($urandom_range(0, 255));
            CPU_IRQ_ACK = ($urandom_range(0, 3) == 0);
            BUS_WE = 1'b0; tb_drive_en = 1'b0; BUS_ADDR = 8'h00;
            r = $urandom_range(0, 9);
            if (r <= 1 && !last_rd) begin
                BUS_ADDR = BASE + 8'($urandom_range(0, 4));
                BUS_WE = 1'b1;
                tb_drive = 8'($urandom_range(0, 255));
                tb_drive_en = 1'b1;
                last_rd = 1'b0;
            end else if (r >= 2 && r <= 4) begin
                BUS_ADDR = BASE + 8'($urandom_range(0, 4));
                last_rd = 1'b1;
            end else begin
                last_rd = 1'b0;
            end
            tick();
        end
        BUS_WE = 1'b0; tb_drive_en = 1'b0; BUS_ADDR = 8'h00;
        SRC_RAISE = 8'h00; CPU_IRQ_ACK = 1'b0;
        tick(); tick();
        chk_en = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        #1;
        test_reset();
        test_level_handshake();
        test_priority();
        test_mask_w1c();
        test_service_block();
        test_reset_mid_raise();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
